// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage, producer side of the fetch/decode link.
// Keeps the PC and issues one request at a time to instruction memory over a
// req/ready handshake. Each returned word is registered together with its pc
// and pc+4 into oID = {pc[96:65], pc4[64:33], instruction[32:1], valid[0]}.
// Optional feature: define IF_MISALIGN_TRAP_EN to add oMisalign and trap on a
// misaligned redirect target. Without it the target's low two bits are cleared.
module fetch_unit #(
    parameter logic [31:0] ResetPc = 32'h0000_0000,
    parameter logic [31:0] PcStep  = 32'd4
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStall,
    input  logic        iFlush,
    input  logic        iBrTrue,
    input  logic [31:0] iBrPc,
    output logic        oImemReq,
    output logic [31:0] oImemAddr,
    input  logic        iImemReady,
    input  logic        iImemRspValid,
    input  logic [31:0] iImemRspData,
`ifdef IF_MISALIGN_TRAP_EN
    output logic        oMisalign,
`endif
    output logic [96:0] oID
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_kill;
    logic [31:0] r_hold_data;
    logic [96:0] r_id;

    logic        w_redir;
    logic        w_accept;
    logic        w_rsp;
    logic        w_deliver;
    logic [31:0] w_del_data;
    logic [31:0] w_br_pc;
    logic        w_trap;
    logic        w_trapped;

    // A redirect is only honoured when decode is not stalled
    assign w_redir  = iBrTrue & ~iStall;
    assign w_accept = (r_state == S_REQ) & iImemReady;
    assign w_rsp    = (r_state == S_WAIT) & iImemRspValid;

`ifdef IF_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_br_pc   = iBrPc;
    assign w_trap    = w_redir & (iBrPc[1:0] != 2'b00);
    assign w_trapped = r_misalign;
    assign oMisalign = r_misalign;

    // Sticky misalignment flag; a new trap takes precedence over a flush clearing it
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_misalign <= 1'b0;
        end else if (w_trap) begin
            r_misalign <= 1'b1;
        end else if (iFlush) begin
            r_misalign <= 1'b0;
        end
    end
`else
    assign w_br_pc   = iBrPc & ~32'h0000_0003;
    assign w_trap    = 1'b0;
    assign w_trapped = 1'b0;
`endif

    // A word reaches oID from a live response or from the hold buffer when decode accepts it
    assign w_deliver  = ~iFlush & ~iStall & ~w_redir &
                        ((w_rsp & ~r_kill) | (r_state == S_HOLD));
    assign w_del_data = (r_state == S_HOLD) ? r_hold_data : iImemRspData;

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and memory request outputs
    always_comb begin
        w_next    = r_state;
        oImemReq  = 1'b0;
        oImemAddr = '0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_trapped || iFlush) w_next = S_REQ;
            end
            S_REQ: begin
                oImemReq  = 1'b1;
                oImemAddr = r_pc;
                if (w_accept) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_rsp) begin
                    if (r_kill || w_redir || iFlush || !iStall) w_next = S_REQ;
                    else                                        w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_redir || iFlush || !iStall) w_next = S_REQ;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_trap) w_next = S_IDLE;
    end

    // PC, outstanding-request bookkeeping, hold buffer and the oID register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_pc        <= ResetPc;
            r_req_pc    <= '0;
            r_kill      <= 1'b0;
            r_hold_data <= '0;
            r_id        <= '0;
        end else begin
            if (w_redir) begin
                r_pc <= w_br_pc;
            end else if (w_accept) begin
                r_pc <= r_pc + PcStep;
            end

            if (w_accept) r_req_pc <= r_pc;

            // The response of a request squashed before it returns is still consumed, then dropped
            if (w_trap) begin
                r_kill <= 1'b0;
            end else if (w_accept && (w_redir || iFlush)) begin
                r_kill <= 1'b1;
            end else if (w_rsp) begin
                r_kill <= 1'b0;
            end else if ((r_state == S_WAIT) && (w_redir || iFlush)) begin
                r_kill <= 1'b1;
            end

            if (w_rsp) r_hold_data <= iImemRspData;

            if (iFlush) begin
                r_id <= '0;
            end else if (iStall) begin
                r_id <= r_id;
            end else if (w_deliver) begin
                r_id <= {r_req_pc, r_req_pc + 32'd4, w_del_data, 1'b1};
            end else begin
                r_id[0] <= 1'b0;
            end
        end
    end

    assign oID = r_id;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic, all
// compared against a transaction-level reference model of the fetch stream.
module tb_fetch_unit;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iStall = 1'b0;
    logic        iFlush = 1'b0;
    logic        iBrTrue = 1'b0;
    logic [31:0] iBrPc = '0;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemReady = 1'b0;
    logic        iImemRspValid = 1'b0;
    logic [31:0] iImemRspData = '0;
    logic [96:0] oID;

    always #5 iClk = ~iClk;

    fetch_unit #(
        .ResetPc(32'h0000_0000),
        .PcStep (32'd4)
    ) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iStall       (iStall),
        .iFlush       (iFlush),
        .iBrTrue      (iBrTrue),
        .iBrPc        (iBrPc),
        .oImemReq     (oImemReq),
        .oImemAddr    (oImemAddr),
        .iImemReady   (iImemReady),
        .iImemRspValid(iImemRspValid),
        .iImemRspData (iImemRspData),
        .oID          (oID)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: program counter, the one fetch in flight, the word parked for decode
    bit          m_on = 1'b0;
    bit          m_idle;
    logic [31:0] m_pc;
    bit          m_inf;
    bit          m_inf_kill;
    logic [31:0] m_inf_pc;
    bit          m_held;
    logic [31:0] m_held_pc;
    logic [96:0] m_id;

    // Memory responder state
    bit          mem_pend = 1'b0;
    int unsigned mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    function automatic logic [31:0] mw(input logic [31:0] a);
        if (a == 32'd8) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [96:0] word_of(input logic [31:0] pc);
        return {pc, pc + 32'd4, mw(pc), 1'b1};
    endfunction

    // One clock: compare outputs with the model, drive inputs, advance model and responder
    task automatic step(input bit rst, input bit stall, input bit flush, input bit br,
                        input logic [31:0] brpc, input bit rdy, input int unsigned dly);
        bit          exp_req;
        bit          rsp;
        bit          rsp_m;
        bit          acc_dut;
        bit          acc_m;
        bit          redir;
        logic [31:0] addr_dut;
        exp_req = m_on && !m_idle && !m_inf && !m_held;
        if (m_on) begin
            checks++;
            if (oImemReq !== exp_req) begin
                errors++;
                $display("FAIL step_req t=%0t: got %b expected %b", $time, oImemReq, exp_req);
            end
            checks++;
            if (oImemAddr !== (exp_req ? m_pc : 32'h0)) begin
                errors++;
                $display("FAIL step_addr t=%0t: got %h expected %h", $time, oImemAddr,
                         exp_req ? m_pc : 32'h0);
            end
            checks++;
            if (oID !== m_id) begin
                errors++;
                $display("FAIL step_oid t=%0t: got %h expected %h", $time, oID, m_id);
            end
        end
        rsp           = !rst && mem_pend && (mem_cnt == 0);
        iRst          = rst;
        iStall        = stall;
        iFlush        = flush;
        iBrTrue       = br;
        iBrPc         = brpc;
        iImemReady    = rdy;
        iImemRspValid = rsp;
        iImemRspData  = rsp ? mw(mem_addr) : $urandom;
        acc_dut       = !rst && oImemReq && rdy;
        addr_dut      = oImemAddr;
        @(posedge iClk);
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (rsp) mem_pend = 1'b0;
            else if (mem_pend && mem_cnt > 0) mem_cnt--;
            if (acc_dut) begin
                mem_pend = 1'b1;
                mem_addr = addr_dut;
                mem_cnt  = dly - 1;
            end
        end
        if (rst) begin
            m_on   = 1'b1;
            m_idle = 1'b1;
            m_pc   = 32'h0;
            m_inf  = 1'b0;
            m_held = 1'b0;
            m_id   = '0;
        end else if (m_on) begin
            redir = br && !stall;
            acc_m = exp_req && rdy;
            rsp_m = m_inf && rsp;
            if (flush) m_id = '0;
            else if (stall) m_id = m_id;
            else if (rsp_m && !m_inf_kill && !redir) m_id = word_of(m_inf_pc);
            else if (m_held && !redir) m_id = word_of(m_held_pc);
            else m_id[0] = 1'b0;
            if (m_held && (flush || !stall)) m_held = 1'b0;
            if (rsp_m && !m_inf_kill && !redir && !flush && stall) begin
                m_held    = 1'b1;
                m_held_pc = m_inf_pc;
            end
            if (rsp_m) m_inf = 1'b0;
            else if (m_inf && (flush || redir)) m_inf_kill = 1'b1;
            if (acc_m) begin
                m_inf      = 1'b1;
                m_inf_pc   = m_pc;
                m_inf_kill = flush || redir;
            end
            if (redir) m_pc = brpc & ~32'h3;
            else if (acc_m) m_pc = m_pc + 32'd4;
            m_idle = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, '0, 0, 1);
        step(1, 0, 0, 0, '0, 0, 1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (oID !== 97'b0) begin
            errors++; $display("FAIL reset_oid: got %h expected 0", oID);
        end
        checks++;
        if (oImemReq !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b expected 0", oImemReq);
        end
        checks++;
        if (oImemAddr !== 32'h0) begin
            errors++; $display("FAIL reset_addr: got %h expected 0", oImemAddr);
        end
        step(0, 0, 0, 0, '0, 0, 1);
        checks++;
        if (oImemReq !== 1'b1 || oImemAddr !== 32'h0) begin
            errors++; $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=0", oImemReq, oImemAddr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] addrs[$];
        logic [31:0] pcs[$];
        bit          vld[7];
        bit          exp_vld[7];
        logic [31:0] a_ref;
        exp_vld = '{0, 0, 1, 0, 1, 0, 1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 0, '0, 1, 1);
            if (oImemReq) addrs.push_back(oImemAddr);
            vld[i] = oID[0];
            if (oID[0]) begin
                pcs.push_back(oID[96:65]);
                checks++;
                if (oID[64:33] !== oID[96:65] + 32'd4) begin
                    errors++; $display("FAIL seq_pc4: got %h expected %h", oID[64:33], oID[96:65] + 32'd4);
                end
            end
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (vld[i] !== exp_vld[i]) begin
                errors++; $display("FAIL seq_valid[%0d]: got %b expected %b", i, vld[i], exp_vld[i]);
            end
        end
        for (int unsigned k = 0; k < 3; k++) begin
            a_ref = 32'(k * 4);
            checks++;
            if (addrs.size() <= k || addrs[k] !== a_ref) begin
                errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", k, (addrs.size() > k) ? addrs[k] : 32'hx, a_ref);
            end
            checks++;
            if (pcs.size() <= k || pcs[k] !== a_ref) begin
                errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", k, (pcs.size() > k) ? pcs[k] : 32'hx, a_ref);
            end
        end
    endtask

    task automatic test_stall();
        logic [96:0] prior;
        prior = {32'd4, 32'd8, mw(32'd4), 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, '0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, '0, 1, 1);
            checks++;
            if (oID !== prior || oImemReq !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: got oID=%h req=%b expected oID=%h req=0", i, oID, oImemReq, prior);
            end
        end
        step(0, 0, 0, 0, '0, 1, 1);
        checks++;
        if (oID !== {32'd8, 32'd12, 32'h0050_0093, 1'b1}) begin
            errors++; $display("FAIL stall_release: got %h expected %h", oID, {32'd8, 32'd12, 32'h0050_0093, 1'b1});
        end
        checks++;
        if (oImemReq !== 1'b1 || oImemAddr !== 32'd12) begin
            errors++; $display("FAIL stall_next_req: got req=%b addr=%h expected req=1 addr=c", oImemReq, oImemAddr);
        end
    endtask

    task automatic test_redirect();
        bit got;
        do_reset();
        step(0, 0, 0, 0, '0, 0, 3);
        step(0, 0, 0, 0, '0, 1, 3);
        step(0, 0, 0, 1, 32'h100, 0, 3);
        step(0, 0, 0, 0, '0, 0, 3);
        step(0, 0, 0, 0, '0, 0, 3);
        checks++;
        if (oImemReq !== 1'b1 || oImemAddr !== 32'h100 || oID[0] !== 1'b0) begin
            errors++; $display("FAIL redir_req: got req=%b addr=%h valid=%b expected req=1 addr=100 valid=0", oImemReq, oImemAddr, oID[0]);
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step(0, 0, 0, 0, '0, 1, 1);
            if (oID[0]) begin
                got = 1'b1;
                checks++;
                if (oID !== word_of(32'h100)) begin
                    errors++; $display("FAIL redir_word: got %h expected %h", oID, word_of(32'h100));
                end
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL redir_timeout: got no valid oID expected word at pc 100");
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(0, 0, 0, 0, '0, 0, 1);
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
        checks++;
        if (oImemAddr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_addr: got %h expected fffffffc", oImemAddr);
        end
        step(0, 0, 0, 0, '0, 1, 1);
        step(0, 0, 0, 0, '0, 0, 1);
        checks++;
        if (oID !== {32'hFFFF_FFFC, 32'h0, mw(32'hFFFF_FFFC), 1'b1}) begin
            errors++; $display("FAIL wrap_oid: got %h expected pc4=0 word", oID);
        end
        checks++;
        if (oImemAddr !== 32'h0 || oImemReq !== 1'b1) begin
            errors++; $display("FAIL wrap_next: got req=%b addr=%h expected req=1 addr=0", oImemReq, oImemAddr);
        end
    endtask

    task automatic test_flush_hold();
        do_reset();
        step(0, 0, 0, 0, '0, 1, 1);
        step(0, 0, 0, 0, '0, 1, 1);
        step(0, 1, 0, 0, '0, 0, 1);
        step(0, 1, 1, 0, '0, 0, 1);
        checks++;
        if (oID !== 97'b0) begin
            errors++; $display("FAIL flush_oid: got %h expected 0", oID);
        end
        checks++;
        if (oImemReq !== 1'b1 || oImemAddr !== 32'd4) begin
            errors++; $display("FAIL flush_next_req: got req=%b addr=%h expected req=1 addr=4", oImemReq, oImemAddr);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, '0, 0, 1);
            checks++;
            if (oID[0] !== 1'b0) begin
                errors++; $display("FAIL flush_no_held[%0d]: got valid=%b expected 0", i, oID[0]);
            end
        end
    endtask

    task automatic test_random();
        bit          st;
        bit          fl;
        bit          b;
        bit          rdy;
        logic [31:0] tgt;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            b   = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step(0, st, fl, b, tgt, rdy, $urandom_range(1, 3));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_flush_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
